// File: rtl/uart_core_if.sv
// Host-side register bus of uart_core: strobes, address/data, read-back and interrupt handshake.
interface uart_core_if;
    logic       read;
    logic       write;
    logic       IACK;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       IRQ;

    modport master (output read, write, IACK, addr, din, input dout, IRQ);
    modport slave  (input read, write, IACK, addr, din, output dout, IRQ);
endinterface

// File: rtl/uart_core.sv
// Register-mapped UART: programmable baud tick, 8-bit TX/RX with optional parity,
// status flags and a level interrupt serviced by IACK.
module uart_core #(
    parameter logic [15:0] RESET_DIV = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    uart_core_if.slave  bus,
    input  logic        rxd,
    output logic        txd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity is the plain XOR of the byte; odd parity is its complement.
    function automatic logic parity_bit(input logic [7:0] data, input logic even);
        return (^data) ^ ~even;
    endfunction

    logic [4:0]  ctrl_r;          // {TIE, RIE, EIE, PEN, EVEN}
    logic [15:0] div_r, div_nxt_s, baud_cnt_r;
    logic        tick_s;
    logic        te_r, rf_r, fe_r, ove_r, pe_r, irq_r, txd_r, irq_cond_s;
    logic [7:0]  tbr_r, rbr_r, dout_r, status_s;
    logic        wr_ctrl_s, wr_tbr_s, wr_dlo_s, wr_dhi_s, rd_stat_s, rd_rbr_s;

    state_t      tx_state_r, tx_state_nxt_s;
    logic [3:0]  tx_tcnt_r, tx_tcnt_nxt_s;
    logic [2:0]  tx_bcnt_r, tx_bcnt_nxt_s;
    logic [7:0]  tx_shift_r, tx_shift_nxt_s;
    logic        tx_par_r, tx_par_nxt_s, tx_load_s, tx_bit_end_s, txd_nxt_s;

    state_t      rx_state_r, rx_state_nxt_s;
    logic [3:0]  rx_tcnt_r, rx_tcnt_nxt_s;
    logic [2:0]  rx_bcnt_r, rx_bcnt_nxt_s;
    logic [7:0]  rx_shift_r, rx_shift_nxt_s;
    logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s, rx_mid_s;
    logic        rx_done_s, rx_fe_set_s, rx_pe_set_s, rx_ovr_s, rx_store_s;

    wire pen_s  = ctrl_r[1];
    wire even_s = ctrl_r[0];

    assign wr_ctrl_s = bus.write && (bus.addr == 2'd0);
    assign wr_tbr_s  = bus.write && (bus.addr == 2'd1) && te_r;
    assign wr_dlo_s  = bus.write && (bus.addr == 2'd2);
    assign wr_dhi_s  = bus.write && (bus.addr == 2'd3);
    assign rd_stat_s = bus.read  && (bus.addr == 2'd0);
    assign rd_rbr_s  = bus.read  && (bus.addr == 2'd1);
    assign status_s  = {te_r, rf_r, fe_r, ove_r, pe_r, 3'b000};

    assign tick_s       = (baud_cnt_r == 16'd0);
    assign tx_bit_end_s = tick_s && (tx_tcnt_r == 4'd15);
    assign rx_mid_s     = tick_s && (rx_tcnt_r == 4'd15);
    assign rx_fall_s    = rx_prev_r && !rx_sync_r;

    // Next divisor value from the two byte-wide write ports.
    always_comb begin
        div_nxt_s = div_r;
        if (wr_dlo_s) begin
            div_nxt_s[7:0] = bus.din;
        end else if (wr_dhi_s) begin
            div_nxt_s[15:8] = bus.din;
        end else begin
            div_nxt_s = div_r;
        end
    end

    // Divisor register and baud down-counter; any divisor write restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r      <= RESET_DIV;
            baud_cnt_r <= RESET_DIV;
        end else begin
            div_r      <= div_nxt_s;
            baud_cnt_r <= (tick_s || wr_dlo_s || wr_dhi_s) ? div_nxt_s : baud_cnt_r - 16'd1;
        end
    end

    // TX next-state: each state holds for 16 ticks, except IDLE which loads TBR as soon as TE drops.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_tcnt_nxt_s  = tx_tcnt_r + {3'd0, tick_s};
        tx_bcnt_nxt_s  = tx_bcnt_r;
        tx_shift_nxt_s = tx_shift_r;
        tx_par_nxt_s   = tx_par_r;
        tx_load_s      = 1'b0;
        case (tx_state_r)
            S_IDLE: begin
                tx_tcnt_nxt_s = 4'd0;
                if (!te_r) begin
                    tx_load_s      = 1'b1;
                    tx_shift_nxt_s = tbr_r;
                    tx_par_nxt_s   = parity_bit(tbr_r, even_s);
                    tx_bcnt_nxt_s  = 3'd0;
                    tx_state_nxt_s = S_START;
                end else begin
                    tx_state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (tx_bit_end_s) tx_state_nxt_s = S_DATA;
                else              tx_state_nxt_s = S_START;
            end
            S_DATA: begin
                if (tx_bit_end_s) begin
                    if (tx_bcnt_r == 3'd7) begin
                        tx_state_nxt_s = pen_s ? S_PARITY : S_STOP;
                    end else begin
                        tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                        tx_bcnt_nxt_s  = tx_bcnt_r + 3'd1;
                    end
                end else begin
                    tx_state_nxt_s = S_DATA;
                end
            end
            S_PARITY: begin
                if (tx_bit_end_s) tx_state_nxt_s = S_STOP;
                else              tx_state_nxt_s = S_PARITY;
            end
            S_STOP: begin
                if (tx_bit_end_s) tx_state_nxt_s = S_IDLE;
                else              tx_state_nxt_s = S_STOP;
            end
            default: tx_state_nxt_s = S_IDLE;
        endcase

        case (tx_state_nxt_s)
            S_START:  txd_nxt_s = 1'b0;
            S_DATA:   txd_nxt_s = tx_shift_nxt_s[0];
            S_PARITY: txd_nxt_s = tx_par_nxt_s;
            default:  txd_nxt_s = 1'b1;
        endcase
    end

    // TX state register; txd is registered from the upcoming state so it changes with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= S_IDLE;
            tx_tcnt_r  <= 4'd0;
            tx_bcnt_r  <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_par_r   <= 1'b0;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_tcnt_r  <= tx_tcnt_nxt_s;
            tx_bcnt_r  <= tx_bcnt_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            tx_par_r   <= tx_par_nxt_s;
            txd_r      <= txd_nxt_s;
        end
    end

    // RX next-state: start is verified half a bit in, then each bit is sampled mid-cell.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_tcnt_nxt_s  = rx_tcnt_r + {3'd0, tick_s};
        rx_bcnt_nxt_s  = rx_bcnt_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_done_s      = 1'b0;
        rx_fe_set_s    = 1'b0;
        rx_pe_set_s    = 1'b0;
        case (rx_state_r)
            S_IDLE: begin
                rx_tcnt_nxt_s = 4'd0;
                if (rx_fall_s) rx_state_nxt_s = S_START;
                else           rx_state_nxt_s = S_IDLE;
            end
            S_START: begin
                if (tick_s && (rx_tcnt_r == 4'd7)) begin
                    rx_tcnt_nxt_s  = 4'd0;
                    rx_bcnt_nxt_s  = 3'd0;
                    rx_state_nxt_s = rx_sync_r ? S_IDLE : S_DATA;
                end else begin
                    rx_state_nxt_s = S_START;
                end
            end
            S_DATA: begin
                if (rx_mid_s) begin
                    rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bcnt_r == 3'd7) begin
                        rx_state_nxt_s = pen_s ? S_PARITY : S_STOP;
                    end else begin
                        rx_bcnt_nxt_s = rx_bcnt_r + 3'd1;
                    end
                end else begin
                    rx_state_nxt_s = S_DATA;
                end
            end
            S_PARITY: begin
                if (rx_mid_s) begin
                    rx_pe_set_s    = (rx_sync_r != parity_bit(rx_shift_r, even_s));
                    rx_state_nxt_s = S_STOP;
                end else begin
                    rx_state_nxt_s = S_PARITY;
                end
            end
            S_STOP: begin
                if (rx_mid_s) begin
                    rx_done_s      = 1'b1;
                    rx_fe_set_s    = !rx_sync_r;
                    rx_state_nxt_s = S_IDLE;
                end else begin
                    rx_state_nxt_s = S_STOP;
                end
            end
            default: rx_state_nxt_s = S_IDLE;
        endcase
    end

    // rxd synchroniser, edge-detect history and RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= S_IDLE;
            rx_tcnt_r  <= 4'd0;
            rx_bcnt_r  <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_meta_r  <= rxd;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            rx_state_r <= rx_state_nxt_s;
            rx_tcnt_r  <= rx_tcnt_nxt_s;
            rx_bcnt_r  <= rx_bcnt_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
        end
    end

    // A byte landing while RBR is being read replaces it without counting as an overrun.
    assign rx_store_s = rx_done_s && (!rf_r || rd_rbr_s);
    assign rx_ovr_s   = rx_done_s && rf_r && !rd_rbr_s;
    assign irq_cond_s = (ctrl_r[4] && te_r) || (ctrl_r[3] && rf_r) ||
                        (ctrl_r[2] && (fe_r || ove_r || pe_r));

    // Host registers, status flags, read data and interrupt line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r <= 5'd0;
            tbr_r  <= 8'd0;
            rbr_r  <= 8'd0;
            te_r   <= 1'b1;
            rf_r   <= 1'b0;
            fe_r   <= 1'b0;
            ove_r  <= 1'b0;
            pe_r   <= 1'b0;
            dout_r <= 8'd0;
            irq_r  <= 1'b0;
        end else begin
            ctrl_r <= wr_ctrl_s ? bus.din[7:3] : ctrl_r;
            tbr_r  <= wr_tbr_s  ? bus.din      : tbr_r;
            rbr_r  <= rx_store_s ? rx_shift_r  : rbr_r;
            te_r   <= tx_load_s | (te_r & ~wr_tbr_s);
            rf_r   <= rx_done_s | (rf_r & ~rd_rbr_s);
            fe_r   <= rx_fe_set_s | (fe_r  & ~rd_stat_s);
            ove_r  <= rx_ovr_s    | (ove_r & ~rd_stat_s);
            pe_r   <= rx_pe_set_s | (pe_r  & ~rd_stat_s);
            irq_r  <= bus.IACK ? 1'b0 : irq_cond_s;
            if (bus.read) begin
                case (bus.addr)
                    2'd0:    dout_r <= status_s;
                    2'd1:    dout_r <= rbr_r;
                    2'd2:    dout_r <= div_r[7:0];
                    2'd3:    dout_r <= div_r[15:8];
                    default: dout_r <= 8'd0;
                endcase
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign bus.dout = dout_r;
    assign bus.IRQ  = irq_r;
    assign txd      = txd_r;

endmodule
